arp_request: RTL
================

# arp_request

Initiator side of ARP for the live-migration datapath. On a command carrying a target IPv4 address, the block sends a broadcast ARP request frame on its AXI-Stream master. It then snoops its AXI-Stream slave for the matching ARP reply and returns the resolved MAC address, retrying on timeout. It sits beside the ARP responder: its master port feeds the egress arbiter, and its slave port taps the ingress stream.

## Interface
- AXIS_DATA_WIDTH, 512, stream data width in bits; the whole request must fit one beat, so this must be ≥ 480.
- AXIS_TUSER_WIDTH, 256, stream sideband width.
- MAC_ADDR, 48'hDA_02_03_04_05_00, local MAC, used as source MAC and SHA.
- IP_ADDR, 32'hC0_A8_01_0A, local IPv4, used as SPA.
- TIMEOUT_CYCLES, 1_000_000, reply wait per attempt in clocks; must be ≥ 1; counter width is $clog2(TIMEOUT_CYCLES+1).
- MAX_RETRIES, 3, retransmissions after the first attempt.
- SRC_PORT, 8'h01, value for tuser[23:16].
- DST_PORT, 8'h01, value for tuser[31:24].

Ports (clock and reset first):
- axis_aclk  in  1  single clock for the whole block.
- axis_reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  resolve command valid.
- req_ready  out  1  high only in IDLE.
- req_ip  in  32  target IPv4 address, captured on req handshake.
- resp_valid  out  1  result valid; held high until resp_ready.
- resp_ready  in  1  result accept.
- resp_ip  out  32  target IP of this result.
- resp_mac  out  48  resolved MAC; 0 when resp_timeout=1.
- resp_timeout  out  1  1 means no reply after all attempts.
- m_axis_tdata / tkeep / tuser / tvalid / tlast, with m_axis_tready in: request frame out.
- s_axis_tdata / tkeep / tuser / tvalid / tlast  in: snooped ingress stream.
- s_axis_tready  out  1  tied to 1; the block never back-pressures.

## Operation
- Byte order: frame byte k is at tdata[8k+7:8k]. Multi-byte fields are in network order, most significant byte at the lowest byte index.
- Request frame is a single beat:
  - Dest MAC FF:FF:FF:FF:FF:FF, source MAC = MAC_ADDR.
  - Type 0x0806, HTYPE 0x0001, PTYPE 0x0800, HLEN 6, PLEN 4, OPER 0x0001.
  - SHA = MAC_ADDR, SPA = IP_ADDR, THA = 0, TPA = captured IP.
  - Bytes 42..59 zero; all higher bytes zero.
  - tkeep low 60 bits set, rest clear; tlast = 1.
  - tuser[15:0] = 60, tuser[23:16] = SRC_PORT, tuser[31:24] = DST_PORT, all other bits 0.
- Ingress SOP tracking: a flag, set at reset, marks the next accepted beat as first-of-packet. It clears on an accepted beat with tlast=0 and sets on an accepted beat with tlast=1.
- Reply match: all of the following on an accepted first beat:
  - State is WAIT.
  - Type 0x0806 and OPER 0x0002.
  - Dest MAC = MAC_ADDR.
  - TPA = IP_ADDR.
  - SPA = captured IP.
- On a match, SHA (bytes 22..27) is captured into resp_mac. Non-first beats and non-matching frames are ignored.
- FSM states: IDLE, SEND, WAIT, DONE.
  - IDLE: req handshake captures req_ip, clears the retry count, and goes to SEND.
  - SEND: m_axis_tvalid=1 with the frame held stable. On handshake, load the timer with 0 and go to WAIT.
  - WAIT: the timer increments each cycle.
    - Match: resp_timeout=0, go to DONE.
    - Timer reaches TIMEOUT_CYCLES-1 with no match: if retry count < MAX_RETRIES, increment it and go to SEND; otherwise resp_mac=0, resp_timeout=1, go to DONE.
  - DONE: resp_valid=1. On resp_ready, go to IDLE.
- A match in the same cycle as timer expiry counts as a success.
- Replies arriving in SEND, DONE or IDLE are discarded.

## Timing
- Reset values:
  - State IDLE.
  - req_ready=1, m_axis_tvalid=0, resp_valid=0.
  - resp_mac=0, resp_ip=0, resp_timeout=0.
  - m_axis data, tkeep, tuser and tlast all 0.
  - s_axis_tready=1.
  - Retry count and timer 0; SOP flag 1.
- Reset asserted mid-operation (including with m_axis_tvalid high) aborts immediately to the reset values; no partial frame is owed.
- Request handshake at cycle N gives m_axis_tvalid=1 at N+1. tvalid holds with stable data until tready; AXIS rules are obeyed.
- Tx handshake at cycle T puts the block in WAIT at T+1. Timeout-driven SEND begins at T+1+TIMEOUT_CYCLES.
- Matching beat accepted at cycle M gives resp_valid=1 at M+1.
- resp handshake at cycle R gives req_ready=1 at R+1.
- Maximum transmissions per command: 1+MAX_RETRIES.

## Structure
- Shared package arp_pkg holds:
  - Constants: ETHERTYPE_ARP, OPER_REQUEST, OPER_REPLY, BROADCAST_MAC, HTYPE_ETH, PTYPE_IPV4.
  - Byte-offset localparams for every ARP field.
  - FSM state enum.
- Field extraction is shared with the ARP responder through one sub-module, arp_hdr_parser. It is combinational, takes tdata, and outputs dest/src MAC, type, oper, sha, spa, tha and tpa.

## Test plan
- req_ip=C0A8010B, m_axis_tready=1 → one beat:
  - bytes 0..5 FF, bytes 6..11 DA0203040500, OPER 0001, TPA C0A8010B.
  - tkeep low 60 bits set, tuser[15:0]=60.
- Same request, then a reply with SPA C0A8010B, SHA 112233445566, dest MAC = MAC_ADDR, 5 cycles later → resp_valid one cycle after the beat, resp_mac=112233445566, resp_timeout=0.
- TIMEOUT_CYCLES=8, MAX_RETRIES=2, no reply → exactly 3 frames spaced 8 cycles after each tx handshake, then resp_timeout=1 and resp_mac=0.
- Each of the following reply variants is ignored and the block still times out:
  - wrong SPA;
  - OPER=1;
  - matching fields on the second beat of a 2-beat packet.
- m_axis_tready low for 4 cycles → tvalid and data stable across the stall; the timer does not start until the handshake.
- axis_reset pulsed while in SEND and while in DONE → all outputs at reset values on the same cycle; the next command works normally.

Source files
------------

// File: rtl/arp_pkg.sv
// Shared ARP definitions: protocol constants, header byte offsets and the
// requester FSM state type, used by the ARP requester and responder.
package arp_pkg;

  localparam logic [15:0] ETHERTYPE_ARP = 16'h0806;
  localparam logic [15:0] OPER_REQUEST  = 16'h0001;
  localparam logic [15:0] OPER_REPLY    = 16'h0002;
  localparam logic [47:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;
  localparam logic [15:0] HTYPE_ETH     = 16'h0001;
  localparam logic [15:0] PTYPE_IPV4    = 16'h0800;
  localparam logic [7:0]  HLEN_ETH      = 8'd6;
  localparam logic [7:0]  PLEN_IPV4     = 8'd4;

  localparam int OFF_DST_MAC = 0;
  localparam int OFF_SRC_MAC = 6;
  localparam int OFF_TYPE    = 12;
  localparam int OFF_HTYPE   = 14;
  localparam int OFF_PTYPE   = 16;
  localparam int OFF_HLEN    = 18;
  localparam int OFF_PLEN    = 19;
  localparam int OFF_OPER    = 20;
  localparam int OFF_SHA     = 22;
  localparam int OFF_SPA     = 28;
  localparam int OFF_THA     = 32;
  localparam int OFF_TPA     = 38;

  localparam int ARP_HDR_BYTES   = 42;
  localparam int ARP_FRAME_BYTES = 60;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} arp_state_t;

  // LSB position of an n-byte field at byte offset off in a byte-reversed
  // vector (frame byte 0 in the top byte), so fields read out in network order.
  function automatic int be_lsb(input int dw, input int off, input int nbytes);
    return dw - 8 * (off + nbytes);
  endfunction

endpackage

// File: rtl/arp_request_if.sv
// AXI-Stream bundle used for the ARP requester's egress and snooped ingress ports.
interface arp_request_if #(
  parameter int DATA_WIDTH = 512,
  parameter int USER_WIDTH = 256
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic [USER_WIDTH-1:0]   tuser;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/arp_hdr_parser.sv
// Combinational Ethernet/ARP header field extraction from a single AXIS beat,
// shared by the ARP requester and responder.
module arp_hdr_parser
  import arp_pkg::*;
#(
  parameter int DATA_WIDTH = 512
) (
  input  logic [DATA_WIDTH-1:0] tdata,
  output logic [47:0]           dst_mac,
  output logic [47:0]           src_mac,
  output logic [15:0]           eth_type,
  output logic [15:0]           oper,
  output logic [47:0]           sha,
  output logic [31:0]           spa,
  output logic [47:0]           tha,
  output logic [31:0]           tpa
);
  localparam int NBYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] be;
  logic                  unused_bits;

  // Byte 0 of the frame ends up in the top byte, so each field is a plain slice.
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_byte_swap
    assign be[8*(NBYTES-1-gi) +: 8] = tdata[8*gi +: 8];
  end

  assign dst_mac  = be[be_lsb(DATA_WIDTH, OFF_DST_MAC, 6) +: 48];
  assign src_mac  = be[be_lsb(DATA_WIDTH, OFF_SRC_MAC, 6) +: 48];
  assign eth_type = be[be_lsb(DATA_WIDTH, OFF_TYPE, 2) +: 16];
  assign oper     = be[be_lsb(DATA_WIDTH, OFF_OPER, 2) +: 16];
  assign sha      = be[be_lsb(DATA_WIDTH, OFF_SHA, 6) +: 48];
  assign spa      = be[be_lsb(DATA_WIDTH, OFF_SPA, 4) +: 32];
  assign tha      = be[be_lsb(DATA_WIDTH, OFF_THA, 6) +: 48];
  assign tpa      = be[be_lsb(DATA_WIDTH, OFF_TPA, 4) +: 32];

  assign unused_bits = ^{be[be_lsb(DATA_WIDTH, OFF_HTYPE, 6) +: 48],
                         be[DATA_WIDTH-8*ARP_HDR_BYTES-1:0]};
endmodule

// File: rtl/arp_request.sv
// ARP initiator: broadcasts a request for a target IPv4 address, snoops the
// ingress stream for the matching reply and returns the MAC, retrying on timeout.
module arp_request
  import arp_pkg::*;
#(
  parameter int          AXIS_DATA_WIDTH  = 512,
  parameter int          AXIS_TUSER_WIDTH = 256,
  parameter logic [47:0] MAC_ADDR         = 48'hDA_02_03_04_05_00,
  parameter logic [31:0] IP_ADDR          = 32'hC0_A8_01_0A,
  parameter int          TIMEOUT_CYCLES   = 1_000_000,
  parameter int          MAX_RETRIES      = 3,
  parameter logic [7:0]  SRC_PORT         = 8'h01,
  parameter logic [7:0]  DST_PORT         = 8'h01
) (
  input  logic          axis_aclk,
  input  logic          axis_reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_ip,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_ip,
  output logic [47:0]   resp_mac,
  output logic          resp_timeout,
  arp_request_if.master m_axis,
  arp_request_if.slave  s_axis
);
  localparam int KEEP_WIDTH  = AXIS_DATA_WIDTH / 8;
  localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RETRY_WIDTH = $clog2(MAX_RETRIES + 2);
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST  = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_WIDTH-1:0] RETRY_LIMIT = RETRY_WIDTH'(MAX_RETRIES);
  localparam logic [KEEP_WIDTH-1:0]  FRAME_KEEP  = KEEP_WIDTH'({ARP_FRAME_BYTES{1'b1}});
  localparam logic [AXIS_TUSER_WIDTH-1:0] FRAME_USER =
    AXIS_TUSER_WIDTH'({DST_PORT, SRC_PORT, 16'(ARP_FRAME_BYTES)});

  arp_state_t                  state_reg;
  logic [31:0]                 req_ip_reg;
  logic [TIMER_WIDTH-1:0]      timer_reg;
  logic [RETRY_WIDTH-1:0]      retry_reg;
  logic                        sop_reg;
  logic                        req_ready_reg, resp_valid_reg, resp_timeout_reg;
  logic [31:0]                 resp_ip_reg;
  logic [47:0]                 resp_mac_reg;
  logic [AXIS_DATA_WIDTH-1:0]  tdata_reg;
  logic [KEEP_WIDTH-1:0]       tkeep_reg;
  logic [AXIS_TUSER_WIDTH-1:0] tuser_reg;
  logic                        tvalid_reg, tlast_reg;

  logic [AXIS_DATA_WIDTH-1:0]  frame_be, frame_tdata;
  logic [47:0]                 rx_dst_mac, rx_src_mac, rx_sha, rx_tha;
  logic [15:0]                 rx_type, rx_oper;
  logic [31:0]                 rx_spa, rx_tpa;
  logic                        reply_match;
  logic                        unused_ok;

  always_comb begin
    frame_be = '0;
    frame_be[be_lsb(AXIS_DATA_WIDTH, OFF_DST_MAC, 6) +: 48] = BROADCAST_MAC;
    frame_be[be_lsb(AXIS_DATA_WIDTH, OFF_SRC_MAC, 6) +: 48] = MAC_ADDR;
    frame_be[be_lsb(AXIS_DATA_WIDTH, OFF_TYPE, 2) +: 16]    = ETHERTYPE_ARP;
    frame_be[be_lsb(AXIS_DATA_WIDTH, OFF_HTYPE, 2) +: 16]   = HTYPE_ETH;
    frame_be[be_lsb(AXIS_DATA_WIDTH, OFF_PTYPE, 2) +: 16]   = PTYPE_IPV4;
    frame_be[be_lsb(AXIS_DATA_WIDTH, OFF_HLEN, 1) +: 8]     = HLEN_ETH;
    frame_be[be_lsb(AXIS_DATA_WIDTH, OFF_PLEN, 1) +: 8]     = PLEN_IPV4;
    frame_be[be_lsb(AXIS_DATA_WIDTH, OFF_OPER, 2) +: 16]    = OPER_REQUEST;
    frame_be[be_lsb(AXIS_DATA_WIDTH, OFF_SHA, 6) +: 48]     = MAC_ADDR;
    frame_be[be_lsb(AXIS_DATA_WIDTH, OFF_SPA, 4) +: 32]     = IP_ADDR;
    frame_be[be_lsb(AXIS_DATA_WIDTH, OFF_TPA, 4) +: 32]     = req_ip;
  end

  for (genvar gi = 0; gi < KEEP_WIDTH; gi++) begin : g_frame_swap
    assign frame_tdata[8*gi +: 8] = frame_be[8*(KEEP_WIDTH-1-gi) +: 8];
  end

  arp_hdr_parser #(.DATA_WIDTH(AXIS_DATA_WIDTH)) u_parser (
    .tdata    (s_axis.tdata),
    .dst_mac  (rx_dst_mac),
    .src_mac  (rx_src_mac),
    .eth_type (rx_type),
    .oper     (rx_oper),
    .sha      (rx_sha),
    .spa      (rx_spa),
    .tha      (rx_tha),
    .tpa      (rx_tpa)
  );

  assign reply_match = (state_reg == WAIT) && s_axis.tvalid && sop_reg &&
                       (rx_type == ETHERTYPE_ARP) && (rx_oper == OPER_REPLY) &&
                       (rx_dst_mac == MAC_ADDR) && (rx_tpa == IP_ADDR) &&
                       (rx_spa == req_ip_reg);

  assign unused_ok = ^{rx_src_mac, rx_tha, s_axis.tkeep, s_axis.tuser};

  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      state_reg        <= IDLE;
      req_ip_reg       <= '0;
      timer_reg        <= '0;
      retry_reg        <= '0;
      sop_reg          <= 1'b1;
      req_ready_reg    <= 1'b1;
      resp_valid_reg   <= 1'b0;
      resp_timeout_reg <= 1'b0;
      resp_ip_reg      <= '0;
      resp_mac_reg     <= '0;
      tdata_reg        <= '0;
      tkeep_reg        <= '0;
      tuser_reg        <= '0;
      tvalid_reg       <= 1'b0;
      tlast_reg        <= 1'b0;
    end else begin
      if (s_axis.tvalid) sop_reg <= s_axis.tlast;
      case (state_reg)
        IDLE: if (req_valid) begin
          req_ip_reg    <= req_ip;
          retry_reg     <= '0;
          req_ready_reg <= 1'b0;
          tdata_reg     <= frame_tdata;
          tkeep_reg     <= FRAME_KEEP;
          tuser_reg     <= FRAME_USER;
          tlast_reg     <= 1'b1;
          tvalid_reg    <= 1'b1;
          state_reg     <= SEND;
        end
        SEND: if (m_axis.tready) begin
          tvalid_reg <= 1'b0;
          timer_reg  <= '0;
          state_reg  <= WAIT;
        end
        WAIT: begin
          // A reply landing on the expiry cycle still wins over the timeout.
          if (reply_match) begin
            resp_mac_reg     <= rx_sha;
            resp_timeout_reg <= 1'b0;
            resp_ip_reg      <= req_ip_reg;
            resp_valid_reg   <= 1'b1;
            state_reg        <= DONE;
          end else if (timer_reg == TIMER_LAST) begin
            if (retry_reg < RETRY_LIMIT) begin
              retry_reg  <= retry_reg + 1'b1;
              tvalid_reg <= 1'b1;
              state_reg  <= SEND;
            end else begin
              resp_mac_reg     <= '0;
              resp_timeout_reg <= 1'b1;
              resp_ip_reg      <= req_ip_reg;
              resp_valid_reg   <= 1'b1;
              state_reg        <= DONE;
            end
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        DONE: if (resp_ready) begin
          resp_valid_reg <= 1'b0;
          req_ready_reg  <= 1'b1;
          state_reg      <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready     = req_ready_reg;
  assign resp_valid    = resp_valid_reg;
  assign resp_ip       = resp_ip_reg;
  assign resp_mac      = resp_mac_reg;
  assign resp_timeout  = resp_timeout_reg;
  assign m_axis.tdata  = tdata_reg;
  assign m_axis.tkeep  = tkeep_reg;
  assign m_axis.tuser  = tuser_reg;
  assign m_axis.tvalid = tvalid_reg;
  assign m_axis.tlast  = tlast_reg;
  assign s_axis.tready = 1'b1;
endmodule
